wb_arbiter: RTL and testbench

//  Writeback stage directly upstream of the register file. Merges two result sources onto the single regfile write port:
//  - ALU results: single-cycle, cannot be back-pressured.
//  - Load results: variable latency, valid/ready, buffered in a small FIFO.

---
 rtl/wb_arbiter.sv | 122 ++++++++++++
 tb/tb_wb_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter merging ALU results and FIFO-buffered loads onto one regfile port
// Optional WB_TRACE_EN: prints each registered write and scoreboard conflicts.
module wb_arbiter #(
    parameter int LQ_DEPTH     = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        aluValid,
    input  logic [4:0]                  aluRd,
    input  logic [31:0]                 aluData,
    output logic                        aluStall,
    input  logic                        ldIssue,
    input  logic [4:0]                  ldIssueRd,
    input  logic                        ldValid,
    input  logic [4:0]                  ldRd,
    input  logic [31:0]                 ldData,
    output logic                        ldReady,
    output logic                        regsWriteEnable,
    output logic [4:0]                  regWriteNum,
    output logic [31:0]                 regWriteData,
    output logic [31:0]                 pendingMask,
    output logic                        sbConflict,
    output logic [$clog2(LQ_DEPTH):0]   lqCount
);
    localparam int PW = $clog2(LQ_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(LQ_DEPTH);
    localparam logic [SW-1:0] LIMIT    = SW'(STARVE_LIMIT);

    logic [4:0]    r_q_rd   [LQ_DEPTH];
    logic [31:0]   r_q_data [LQ_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;
    logic          r_ld_wb;
    logic          r_we;
    logic [4:0]    r_num;
    logic [31:0]   r_data;
    logic [31:0]   r_mask;
    logic          r_conflict;

    logic          w_alu_req;
    logic          w_nonempty;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_set;
    logic [31:0]   w_clr;

    assign w_alu_req  = aluValid && (aluRd != 5'd0);
    assign w_nonempty = (r_count != '0);
    assign ldReady    = (r_count != FULL_CNT);
    // Writes to x0 complete the handshake but are never queued.
    assign w_push     = ldValid && ldReady && (ldRd != 5'd0);
    assign w_pop      = !w_alu_req && w_nonempty;
    assign w_set      = (ldIssue && ldIssueRd != 5'd0) ? (32'd1 << ldIssueRd) : 32'd0;
    assign w_clr      = r_ld_wb ? (32'd1 << r_num) : 32'd0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_rd[r_wptr]   <= ldRd;
            r_q_data[r_wptr] <= ldData;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_starve   <= '0;
            r_ld_wb    <= 1'b0;
            r_we       <= 1'b0;
            r_num      <= 5'd0;
            r_data     <= 32'd0;
            r_mask     <= 32'd0;
            r_conflict <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;

            if (w_pop || !w_nonempty)         r_starve <= '0;
            else if (r_starve != LIMIT)       r_starve <= r_starve + 1'b1;

            r_we    <= w_alu_req || w_pop;
            r_ld_wb <= w_pop;
            if (w_alu_req) begin
                r_num  <= aluRd;
                r_data <= aluData;
            end else if (w_pop) begin
                r_num  <= r_q_rd[r_rptr];
                r_data <= r_q_data[r_rptr];
            end

            // Set after clear so a same-cycle reissue keeps the bit pending.
            r_mask     <= ((r_mask & ~w_clr) | w_set) & 32'hFFFF_FFFE;
            r_conflict <= ldIssue && (ldIssueRd != 5'd0) && r_mask[ldIssueRd];
        end
    end

    assign aluStall        = (r_starve == LIMIT);
    assign regsWriteEnable = r_we;
    assign regWriteNum     = r_num;
    assign regWriteData    = r_data;
    assign pendingMask     = r_mask;
    assign sbConflict      = r_conflict;
    assign lqCount         = r_count;

`ifdef WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (rstn && (w_alu_req || w_pop))
            $display("wb x%0d = %h src=%s", w_alu_req ? aluRd : r_q_rd[r_rptr],
                     w_alu_req ? aluData : r_q_data[r_rptr], w_alu_req ? "alu" : "ld");
        if (rstn && r_conflict)
            $display("wb warning: load issued to already-pending x%0d", ldIssueRd);
    end
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rstn;
    logic        aluValid;
    logic [4:0]  aluRd;
    logic [31:0] aluData;
    logic        aluStall;
    logic        ldIssue;
    logic [4:0]  ldIssueRd;
    logic        ldValid;
    logic [4:0]  ldRd;
    logic [31:0] ldData;
    logic        ldReady;
    logic        regsWriteEnable;
    logic [4:0]  regWriteNum;
    logic [31:0] regWriteData;
    logic [31:0] pendingMask;
    logic        sbConflict;
    logic [2:0]  lqCount;

    int n_assert = 0;
    int n_fail   = 0;

    wb_arbiter #(.LQ_DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rstn(rstn),
        .aluValid(aluValid), .aluRd(aluRd), .aluData(aluData), .aluStall(aluStall),
        .ldIssue(ldIssue), .ldIssueRd(ldIssueRd),
        .ldValid(ldValid), .ldRd(ldRd), .ldData(ldData), .ldReady(ldReady),
        .regsWriteEnable(regsWriteEnable), .regWriteNum(regWriteNum), .regWriteData(regWriteData),
        .pendingMask(pendingMask), .sbConflict(sbConflict), .lqCount(lqCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic [4:0] rd, input logic [31:0] d);
        chk({tag, "_we"}, {31'd0, regsWriteEnable}, 32'd1);
        chk({tag, "_num"}, {27'd0, regWriteNum}, {27'd0, rd});
        chk({tag, "_data"}, regWriteData, d);
    endtask

    initial begin
        rstn = 1'b0; aluValid = 0; aluRd = 0; aluData = 0;
        ldIssue = 0; ldIssueRd = 0; ldValid = 0; ldRd = 0; ldData = 0;
        tick(); tick();
        rstn = 1'b1;
        tick();
        chk("rst_we", {31'd0, regsWriteEnable}, 32'd0);
        chk("rst_num", {27'd0, regWriteNum}, 32'd0);
        chk("rst_data", regWriteData, 32'd0);
        chk("rst_mask", pendingMask, 32'd0);
        chk("rst_conf", {31'd0, sbConflict}, 32'd0);
        chk("rst_stall", {31'd0, aluStall}, 32'd0);
        chk("rst_cnt", {29'd0, lqCount}, 32'd0);
        chk("rst_rdy", {31'd0, ldReady}, 32'd1);

        // ALU only
        aluValid = 1; aluRd = 5; aluData = 32'hDEADBEEF;
        tick();
        aluValid = 0;
        chk_wr("alu", 5'd5, 32'hDEADBEEF);
        tick();
        chk("alu_idle_we", {31'd0, regsWriteEnable}, 32'd0);
        chk("alu_hold_num", {27'd0, regWriteNum}, 32'd5);

        // Load path: two-cycle latency, scoreboard clears the cycle after the write
        ldIssue = 1; ldIssueRd = 7;
        tick();
        ldIssue = 0;
        chk("ld_mask_set", pendingMask, 32'h80);
        ldValid = 1; ldRd = 7; ldData = 32'h1234;
        tick();
        ldValid = 0;
        chk("ld_cnt1", {29'd0, lqCount}, 32'd1);
        chk("ld_no_wr_yet", {31'd0, regsWriteEnable}, 32'd0);
        tick();
        chk_wr("ld", 5'd7, 32'h1234);
        chk("ld_mask_still", pendingMask, 32'h80);
        tick();
        chk("ld_mask_clr", pendingMask, 32'h0);
        chk("ld_we_off", {31'd0, regsWriteEnable}, 32'd0);

        // ldRd == 0 is accepted but dropped
        ldValid = 1; ldRd = 0; ldData = 32'h55;
        tick();
        ldValid = 0;
        chk("x0_cnt", {29'd0, lqCount}, 32'd0);
        tick();
        chk("x0_no_wr", {31'd0, regsWriteEnable}, 32'd0);

        // Double issue to x3
        ldIssue = 1; ldIssueRd = 3;
        tick();
        chk("conf_first", {31'd0, sbConflict}, 32'd0);
        tick();
        ldIssue = 0;
        chk("conf_pulse", {31'd0, sbConflict}, 32'd1);
        tick();
        chk("conf_drop", {31'd0, sbConflict}, 32'd0);
        chk("conf_mask", pendingMask, 32'h8);

        // Contention and starvation stall
        aluValid = 1; aluRd = 1; aluData = 32'hA;
        ldValid = 1; ldRd = 10; ldData = 32'hBB;
        tick();
        ldValid = 0;
        chk("st_cnt", {29'd0, lqCount}, 32'd1);
        chk("st_stall0", {31'd0, aluStall}, 32'd0);
        tick();
        chk("st_stall1", {31'd0, aluStall}, 32'd0);
        tick();
        chk("st_stall2", {31'd0, aluStall}, 32'd0);
        tick();
        chk("st_stall3", {31'd0, aluStall}, 32'd1);
        chk_wr("st_alu", 5'd1, 32'hA);
        aluValid = 0;
        tick();
        chk_wr("st_drain", 5'd10, 32'hBB);
        chk("st_stall_drop", {31'd0, aluStall}, 32'd0);
        chk("st_cnt0", {29'd0, lqCount}, 32'd0);

        // Full FIFO with ALU busy; fifth load held until space opens
        aluValid = 1; aluRd = 2; aluData = 32'h22;
        for (int i = 0; i < 4; i++) begin
            ldValid = 1; ldRd = 5'(11 + i); ldData = 32'(32'h100 + i);
            tick();
        end
        chk("full_cnt", {29'd0, lqCount}, 32'd4);
        chk("full_rdy", {31'd0, ldReady}, 32'd0);
        ldRd = 15; ldData = 32'h104;
        tick();
        chk("full_hold_cnt", {29'd0, lqCount}, 32'd4);
        aluValid = 0;
        tick();
        chk_wr("full_pop0", 5'd11, 32'h100);
        chk("full_cnt3", {29'd0, lqCount}, 32'd3);
        chk("full_rdy1", {31'd0, ldReady}, 32'd1);
        tick();
        ldValid = 0;
        chk_wr("full_pop1", 5'd12, 32'h101);
        chk("full_pushpop_cnt", {29'd0, lqCount}, 32'd3);
        tick();
        chk_wr("full_pop2", 5'd13, 32'h102);
        tick();
        chk_wr("full_pop3", 5'd14, 32'h103);
        tick();
        chk_wr("full_pop4", 5'd15, 32'h104);
        chk("full_empty", {29'd0, lqCount}, 32'd0);

        // Reissue of x9 in the cycle its load writeback is visible: set wins
        ldIssue = 1; ldIssueRd = 9;
        tick();
        ldIssue = 0;
        ldValid = 1; ldRd = 9; ldData = 32'h99;
        tick();
        ldValid = 0;
        tick();
        chk_wr("x9_wr", 5'd9, 32'h99);
        ldIssue = 1; ldIssueRd = 9;
        tick();
        ldIssue = 0;
        chk("x9_mask_kept", pendingMask & 32'h200, 32'h200);
        tick();

        // Asynchronous reset with three loads queued
        ldIssue = 1; ldIssueRd = 20;
        aluValid = 1; aluRd = 4; aluData = 32'h44;
        for (int i = 0; i < 3; i++) begin
            ldValid = 1; ldRd = 5'(20 + i); ldData = 32'(32'h200 + i);
            tick();
            ldIssue = 0;
        end
        chk("pre_rst_cnt", {29'd0, lqCount}, 32'd3);
        #2;
        rstn = 1'b0;
        #1;
        chk("mrst_we", {31'd0, regsWriteEnable}, 32'd0);
        chk("mrst_num", {27'd0, regWriteNum}, 32'd0);
        chk("mrst_data", regWriteData, 32'd0);
        chk("mrst_mask", pendingMask, 32'd0);
        chk("mrst_cnt", {29'd0, lqCount}, 32'd0);
        chk("mrst_rdy", {31'd0, ldReady}, 32'd1);
        chk("mrst_stall", {31'd0, aluStall}, 32'd0);
        aluValid = 0; ldValid = 0;
        #1;
        rstn = 1'b1;
        tick();
        chk("post_rst_no_drain", {31'd0, regsWriteEnable}, 32'd0);
        chk("post_rst_cnt", {29'd0, lqCount}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
